// File: rtl/usart_rx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : usart_rx_pkg                                                    |
// | Brief    : Shared receiver definitions: state encoding and default widths. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package usart_rx_pkg;

   localparam int USART_DATA_BITS = 8;
   localparam int CPB_WIDTH       = 12;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/usart_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : usart_sync                                                      |
// | Brief    : Two-flop synchronizer for the serial line; resets to idle (1).  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module usart_sync (
   input  logic serial_clock,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge serial_clock or negedge reset_n) begin
      if (!reset_n) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
      end else begin
         r_meta <= d;
         r_sync <= r_meta;
      end
   end

   assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/usart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : usart_rx                                                        |
// | Brief    : 8N1 serial receiver with valid/ack handoff, framing/overrun.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module usart_rx
   import usart_rx_pkg::*;
#(
   parameter int DATA_BITS = USART_DATA_BITS
) (
   input  logic                 serial_clock,
   input  logic                 reset_n,
   input  logic [CPB_WIDTH-1:0] clocks_per_bit,
   input  logic                 rx_pin,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 valid,
   input  logic                 ack,
   output logic                 framing_error,
   output logic                 overrun
);

   localparam int              IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

   logic                 w_rxs;
   rx_state_t            r_state;
   rx_state_t            w_state_next;
   logic [CPB_WIDTH-1:0] r_cpb;
   logic [CPB_WIDTH-1:0] r_cnt;
   logic [CPB_WIDTH-1:0] w_cnt_next;
   logic [IDX_W-1:0]     r_idx;
   logic [IDX_W-1:0]     w_idx_next;
   logic [DATA_BITS-1:0] r_shift;
   logic                 w_tick;
   logic                 w_shift_en;
   logic                 w_latch_cpb;
   logic                 w_deliver;
   logic                 w_frame_err;

   usart_sync u_sync (
      .serial_clock (serial_clock),
      .reset_n      (reset_n),
      .d            (rx_pin),
      .q            (w_rxs)
   );

   assign w_tick = (r_cnt == '0);

   // Half-period first load centres every later sample in its bit cell.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = w_tick ? r_cnt : r_cnt - CPB_WIDTH'(1);
      w_idx_next   = r_idx;
      w_shift_en   = 1'b0;
      w_latch_cpb  = 1'b0;
      w_deliver    = 1'b0;
      w_frame_err  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_rxs) begin
               w_state_next = ST_START;
               w_cnt_next   = clocks_per_bit >> 1;
               w_latch_cpb  = 1'b1;
            end
         end
         ST_START: begin
            if (w_tick) begin
               if (w_rxs) begin
                  w_state_next = ST_IDLE;
               end else begin
                  w_state_next = ST_DATA;
                  w_cnt_next   = r_cpb;
                  w_idx_next   = '0;
               end
            end
         end
         ST_DATA: begin
            if (w_tick) begin
               w_shift_en = 1'b1;
               w_cnt_next = r_cpb;
               w_idx_next = r_idx + IDX_W'(1);
               if (r_idx == LAST_IDX) begin
                  w_state_next = ST_STOP;
               end
            end
         end
         ST_STOP: begin
            if (w_tick) begin
               if (w_rxs) begin
                  w_deliver    = 1'b1;
                  w_state_next = ST_IDLE;
               end else begin
                  w_frame_err  = 1'b1;
                  w_state_next = ST_BREAK;
               end
            end
         end
         ST_BREAK: begin
            if (w_rxs) begin
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge serial_clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge serial_clock or negedge reset_n) begin
      if (!reset_n) begin
         r_cpb   <= '0;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_shift <= '0;
      end else begin
         r_cnt <= w_cnt_next;
         r_idx <= w_idx_next;
         if (w_latch_cpb) begin
            r_cpb <= clocks_per_bit;
         end
         if (w_shift_en) begin
            r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
         end
      end
   end

   // A delivery that coincides with an ack replaces the byte and keeps valid set.
   always_ff @(posedge serial_clock or negedge reset_n) begin
      if (!reset_n) begin
         data_out      <= '0;
         valid         <= 1'b0;
         framing_error <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         framing_error <= w_frame_err;
         overrun       <= 1'b0;
         if (w_deliver) begin
            if (!valid || ack) begin
               data_out <= r_shift;
               valid    <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (valid && ack) begin
            valid <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire
